// File: rtl/esm_issue_selector.sv
// ESM issue selector: picks one ready buffer entry per cycle and offers it
// on a valid/ready grant, masking issued entries until they retire.
module esm_issue_selector #(
    parameter int unsigned BS   = 16,
    parameter logic [15:0] SEED = 16'hACE1,
    localparam int unsigned BB  = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          proceed,
    input  logic [0:BS-1] independent_instr,
    input  logic [1:0]    mode,
    output logic          grant_valid,
    output logic [BB-1:0] grant_index,
    input  logic          grant_ready,
    input  logic          retire_valid,
    input  logic [BB-1:0] retire_index,
    output logic [BB:0]   eligible_count
);

    logic [BS-1:0] r_cand;
    logic [BS-1:0] r_pending;
    logic [15:0]   r_lfsr;
    logic [BB-1:0] r_rr_ptr;
    logic          r_grant_valid;
    logic [BB-1:0] r_grant_index;
    logic [BB:0]   r_count;

    logic [BS-1:0] w_instr;
    logic [BS-1:0] w_acc_mask;
    logic [BS-1:0] w_eligible;
    logic [BS-1:0] w_pend_nxt;
    logic [15:0]   w_lfsr_nxt;
    logic [BB-1:0] w_start;
    logic [BB-1:0] w_sel;
    logic [BB-1:0] w_idx;
    logic          w_found;
    logic          w_accept;
    logic          w_load;
    logic [BB:0]   w_count;

    // Input is declared ascending; normalise so bit i is entry i.
    always_comb begin
        w_instr = '0;
        for (int i = 0; i < BS; i++) begin
            w_instr[i] = independent_instr[i];
        end
    end

    assign w_accept = r_grant_valid & grant_ready;

    always_comb begin
        w_acc_mask = '0;
        if (w_accept) begin
            w_acc_mask[r_grant_index] = 1'b1;
        end
    end

    assign w_eligible = r_cand & ~r_pending & ~w_acc_mask;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                      ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        w_start = '0;
        case (mode)
            2'd0:    w_start = r_lfsr[BB-1:0];
            2'd1:    w_start = r_rr_ptr;
            default: w_start = '0;
        endcase
    end

    // Circular scan from the start pointer; index arithmetic wraps at BS.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < BS; i++) begin
            w_idx = w_start + BB'(i);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_load = proceed & w_found & (~r_grant_valid | w_accept);

    // Accept is applied after retire so it wins on a same-index collision.
    always_comb begin
        w_pend_nxt = r_pending;
        if (retire_valid) begin
            w_pend_nxt[retire_index] = 1'b0;
        end
        if (w_accept) begin
            w_pend_nxt[r_grant_index] = 1'b1;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < BS; i++) begin
            w_count = w_count + (BB+1)'(r_cand[i] & ~r_pending[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand        <= '0;
            r_pending     <= '0;
            r_lfsr        <= SEED;
            r_rr_ptr      <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            r_count       <= '0;
        end else begin
            r_cand    <= w_instr;
            r_pending <= w_pend_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_count   <= w_count;
            if (w_accept) begin
                r_rr_ptr <= r_grant_index + BB'(1);
            end
            if (w_load) begin
                r_grant_valid <= 1'b1;
                r_grant_index <= w_sel;
            end else if (w_accept) begin
                r_grant_valid <= 1'b0;
            end
        end
    end

    assign grant_valid    = r_grant_valid;
    assign grant_index    = r_grant_index;
    assign eligible_count = r_count;

endmodule

// File: tb/tb_esm_issue_selector.sv
// Directed bench for esm_issue_selector (BS=16, SEED=16'hACE1).
// Inputs change and outputs are sampled on the falling edge.
module tb_esm_issue_selector;

    localparam int BS = 16;
    localparam int BB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          proceed = 1'b0;
    logic [0:BS-1] ins = '0;
    logic [1:0]    mode = 2'd0;
    logic          gv;
    logic [BB-1:0] gi;
    logic          gr = 1'b0;
    logic          rv = 1'b0;
    logic [BB-1:0] ri = '0;
    logic [BB:0]   cnt;

    int vec_n  = 0;
    int miss_n = 0;

    always #5 clk = ~clk;

    esm_issue_selector #(
        .BS   (BS),
        .SEED (16'hACE1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .proceed           (proceed),
        .independent_instr (ins),
        .mode              (mode),
        .grant_valid       (gv),
        .grant_index       (gi),
        .grant_ready       (gr),
        .retire_valid      (rv),
        .retire_index      (ri),
        .eligible_count    (cnt)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] st,
                                        input logic [15:0] taken);
        logic [3:0] k;
        for (int i = 0; i < 16; i++) begin
            k = st + 4'(i);
            if (!taken[k]) return k;
        end
        return 4'd0;
    endfunction

    task automatic do_reset();
        rst     = 1'b0;
        proceed = 1'b1;
        gr      = 1'b0;
        rv      = 1'b0;
        ri      = '0;
        ins     = '0;
        mode    = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ins = '1;
        proceed = 1'b1;
        gr = 1'b1;
        repeat (3) @(negedge clk);
        vec_n++;
        if (gv !== 1'b0 || gi !== 4'd0 || cnt !== 5'd0) begin
            miss_n++;
            $display("FAIL reset_state: v=%0b i=%0d c=%0d want 0/0/0",
                     gv, gi, cnt);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 2'd2; gr = 1'b1;
        ins[3] = 1'b1; ins[9] = 1'b1;
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0) begin
            miss_n++;
            $display("FAIL fixed_latency: v=%0b want 0", gv);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd3 || cnt !== 5'd2) begin
            miss_n++;
            $display("FAIL fixed_g3: v=%0b i=%0d c=%0d want 1/3/2",
                     gv, gi, cnt);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd9 || cnt !== 5'd2) begin
            miss_n++;
            $display("FAIL fixed_g9: v=%0b i=%0d c=%0d want 1/9/2",
                     gv, gi, cnt);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0 || cnt !== 5'd1) begin
            miss_n++;
            $display("FAIL fixed_drain: v=%0b c=%0d want 0/1", gv, cnt);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0 || cnt !== 5'd0) begin
            miss_n++;
            $display("FAIL fixed_allpend: v=%0b c=%0d want 0/0", gv, cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] prev;
        do_reset();
        mode = 2'd1; gr = 1'b1; ins = '1;
        prev = '0;
        @(negedge clk);
        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            vec_n++;
            if (gv !== 1'b1 || gi !== 4'(n % 16)) begin
                miss_n++;
                $display("FAIL rr_seq[%0d]: v=%0b i=%0d want 1/%0d",
                         n, gv, gi, n % 16);
            end
            rv = (n > 0);
            ri = prev;
            prev = gi;
        end
        rv = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 2'd2; ins[5] = 1'b1;
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd5) begin
            miss_n++;
            $display("FAIL bp_offer: v=%0b i=%0d want 1/5", gv, gi);
        end
        ins[5] = 1'b0;
        mode = 2'd1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            vec_n++;
            if (gv !== 1'b1 || gi !== 4'd5) begin
                miss_n++;
                $display("FAIL bp_hold[%0d]: v=%0b i=%0d want 1/5",
                         n, gv, gi);
            end
        end
        gr = 1'b1;
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0) begin
            miss_n++;
            $display("FAIL bp_accept: v=%0b want 0", gv);
        end
        ins[5] = 1'b1;
        repeat (3) @(negedge clk);
        vec_n++;
        if (gv !== 1'b0 || cnt !== 5'd0) begin
            miss_n++;
            $display("FAIL bp_pending5: v=%0b c=%0d want 0/0", gv, cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] l;
        logic [15:0] seen;
        logic [15:0] model;
        logic [3:0]  p;
        do_reset();
        mode = 2'd0; gr = 1'b1; ins = '1;
        l = lfsr_step(16'hACE1);
        seen = '0;
        model = '0;
        @(negedge clk);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            p = pick(l[3:0], model);
            vec_n++;
            if (gv !== 1'b1 || gi !== p || seen[gi]) begin
                miss_n++;
                $display("FAIL rand_seq[%0d]: v=%0b i=%0d want 1/%0d unique",
                         n, gv, gi, p);
            end
            seen[gi] = 1'b1;
            model[p] = 1'b1;
            l = lfsr_step(l);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0 || seen !== 16'hFFFF) begin
            miss_n++;
            $display("FAIL rand_end: v=%0b seen=%h want 0/ffff", gv, seen);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        mode = 2'd2; gr = 1'b1; ins[7] = 1'b1;
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd7) begin
            miss_n++;
            $display("FAIL sc_offer: v=%0b i=%0d want 1/7", gv, gi);
        end
        rv = 1'b1; ri = 4'd7;
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b0) begin
            miss_n++;
            $display("FAIL sc_collide: v=%0b want 0", gv);
        end
        @(negedge clk);
        rv = 1'b0;
        vec_n++;
        if (gv !== 1'b0) begin
            miss_n++;
            $display("FAIL sc_retire: v=%0b want 0", gv);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd7 || cnt !== 5'd1) begin
            miss_n++;
            $display("FAIL sc_regrant: v=%0b i=%0d c=%0d want 1/7/1",
                     gv, gi, cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 2'd1; gr = 1'b1; ins[14] = 1'b1;
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd14) begin
            miss_n++;
            $display("FAIL wrap_g14: v=%0b i=%0d want 1/14", gv, gi);
        end
        ins = '0; ins[0] = 1'b1; ins[3] = 1'b1;
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd0) begin
            miss_n++;
            $display("FAIL wrap_g0: v=%0b i=%0d want 1/0", gv, gi);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd3) begin
            miss_n++;
            $display("FAIL wrap_g3: v=%0b i=%0d want 1/3", gv, gi);
        end
    endtask

    task automatic test_reset_pulse();
        logic [15:0] l;
        do_reset();
        mode = 2'd1; gr = 1'b1; ins = '1;
        repeat (4) @(negedge clk);
        gr = 1'b0;
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd2) begin
            miss_n++;
            $display("FAIL pulse_pre: v=%0b i=%0d want 1/2", gv, gi);
        end
        #2 rst = 1'b0;
        #1;
        vec_n++;
        if (gv !== 1'b0 || gi !== 4'd0 || cnt !== 5'd0) begin
            miss_n++;
            $display("FAIL pulse_async: v=%0b i=%0d c=%0d want 0/0/0",
                     gv, gi, cnt);
        end
        #1 rst = 1'b1;
        gr = 1'b1;
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd0 || cnt !== 5'd16) begin
            miss_n++;
            $display("FAIL pulse_rr0: v=%0b i=%0d c=%0d want 1/0/16",
                     gv, gi, cnt);
        end
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== 4'd1) begin
            miss_n++;
            $display("FAIL pulse_rr1: v=%0b i=%0d want 1/1", gv, gi);
        end
        mode = 2'd0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        l = lfsr_step(16'hACE1);
        repeat (2) @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== l[3:0]) begin
            miss_n++;
            $display("FAIL pulse_lfsr0: v=%0b i=%0d want 1/%0d",
                     gv, gi, l[3:0]);
        end
        l = lfsr_step(l);
        @(negedge clk);
        vec_n++;
        if (gv !== 1'b1 || gi !== pick(l[3:0], 16'h0001)) begin
            miss_n++;
            $display("FAIL pulse_lfsr1: v=%0b i=%0d want 1/%0d",
                     gv, gi, pick(l[3:0], 16'h0001));
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_random();
        test_same_cycle();
        test_wrap();
        test_reset_pulse();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_n, miss_n);
        $finish;
    end

endmodule
